// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with a 2-entry skid buffer, flush, and control masking on bubbles.
// Optional PIPE_STAGE_PERF_EN adds stall/bubble/flush counters.
module pipe_stage_elastic #(
  parameter int CTRL_W    = 4,
  parameter int DATA_W    = 101,
  parameter bit ZERO_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_r;
  logic                out_valid_r;
  logic                in_ready_r;
  logic [CTRL_W-1:0]   main_ctrl_r;
  logic [DATA_W-1:0]   main_data_r;
  logic [CTRL_W-1:0]   skid_ctrl_r;
  logic [DATA_W-1:0]   skid_data_r;
  logic                in_xfer_s;
  logic                out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_r & ~flush;
  assign out_xfer_s = out_valid_r & out_ready;

  // Stage state, handshake flags and both payload entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
    end else if (flush) begin
      // Main payload is kept so the data bundle still shows its last value.
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
            state_r     <= ONE;
          end else if (in_xfer_s) begin
            skid_ctrl_r <= in_ctrl;
            skid_data_r <= in_data;
            state_r     <= TWO;
            in_ready_r  <= 1'b0;
          end else if (out_xfer_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= ONE;
          end
        end
        TWO: begin
          if (out_xfer_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
            state_r     <= ONE;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= TWO;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign out_ctrl  = out_valid_r ? main_ctrl_r : {CTRL_W{1'b0}};
  assign out_data  = (ZERO_DATA && !out_valid_r) ? {DATA_W{1'b0}} : main_data_r;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] bubble_cnt_r;
  logic [31:0] flush_cnt_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
      flush_cnt_r  <= 32'd0;
    end else begin
      if (out_valid_r && !out_ready) stall_cnt_r <= stall_cnt_r + 32'd1;
      if (!out_valid_r)              bubble_cnt_r <= bubble_cnt_r + 32'd1;
      if (flush && (state_r != EMPTY)) flush_cnt_r <= flush_cnt_r + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed vector table plus a queue-model backpressure run for pipe_stage_elastic.
// Exercises both ZERO_DATA settings; counter checks only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_elastic;

  localparam int CW = 4;
  localparam int DW = 101;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, in_ready_z, out_valid_z;
  logic [CW-1:0] out_ctrl, out_ctrl_z;
  logic [DW-1:0] out_data, out_data_z;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt, flush_cnt;
  logic [31:0]   stall_cnt_z, bubble_cnt_z, flush_cnt_z;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1'b1)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_z), .out_ready(out_ready),
    .out_ctrl(out_ctrl_z), .out_data(out_data_z)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt_z), .bubble_cnt(bubble_cnt_z), .flush_cnt(flush_cnt_z)
`endif
  );

  typedef struct {
    logic          rst, flush, iv, ordy;
    logic [CW-1:0] ictrl;
    logic [DW-1:0] idata;
    logic          e_ov, e_ir;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data, e_data_z;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [CW-1:0] ic, logic [DW-1:0] id,
                              logic ordy, logic ov, logic ir, logic [CW-1:0] ec,
                              logic [DW-1:0] ed, logic [DW-1:0] edz);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ictrl = ic; v.idata = id; v.ordy = ordy;
    v.e_ov = ov; v.e_ir = ir; v.e_ctrl = ec; v.e_data = ed; v.e_data_z = edz;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic f, logic iv, logic [CW-1:0] ic, logic [DW-1:0] id, logic ordy);
    rst = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
  endtask

  initial begin
    logic [CW-1:0] B;
    logic [CW-1:0] Z;
    int            seq;
    logic          in_x, out_x;
    B = 4'b1011;
    Z = 4'b0000;
    drive(1'b1, 1'b0, 1'b0, Z, 101'd0, 1'b0);

    // rst flush iv ctrl data ordy | ov ir ctrl data data_z
    tbl.push_back(mk(1, 0, 0, Z, 101'h0, 0,   0, 1, Z, 101'h0, 101'h0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 1, B, 101'(i), 1,   1, 1, B, 101'(i), 101'(i)));
    tbl.push_back(mk(0, 0, 0, Z, 101'h0, 1,   0, 1, Z, 101'h5, 101'h0));
    tbl.push_back(mk(0, 0, 1, B, 101'hA, 0,   1, 1, B, 101'hA, 101'hA));
    tbl.push_back(mk(0, 0, 1, B, 101'hB, 0,   1, 0, B, 101'hA, 101'hA));
    tbl.push_back(mk(0, 0, 1, B, 101'hC, 0,   1, 0, B, 101'hA, 101'hA));
    tbl.push_back(mk(0, 0, 1, B, 101'hC, 1,   1, 1, B, 101'hB, 101'hB));
    tbl.push_back(mk(0, 0, 1, B, 101'hC, 1,   1, 1, B, 101'hC, 101'hC));
    tbl.push_back(mk(0, 0, 0, Z, 101'h0, 1,   0, 1, Z, 101'hC, 101'h0));
    tbl.push_back(mk(0, 0, 1, B, 101'hA, 0,   1, 1, B, 101'hA, 101'hA));
    tbl.push_back(mk(0, 0, 1, B, 101'hB, 0,   1, 0, B, 101'hA, 101'hA));
    tbl.push_back(mk(0, 1, 1, B, 101'hC, 0,   0, 1, Z, 101'hA, 101'h0));
    tbl.push_back(mk(0, 0, 0, Z, 101'h0, 1,   0, 1, Z, 101'hA, 101'h0));
    tbl.push_back(mk(0, 0, 1, B, 101'hA, 0,   1, 1, B, 101'hA, 101'hA));
    tbl.push_back(mk(0, 0, 1, B, 101'hB, 0,   1, 0, B, 101'hA, 101'hA));
    tbl.push_back(mk(1, 1, 1, B, 101'hC, 0,   0, 1, Z, 101'h0, 101'h0));
    tbl.push_back(mk(0, 0, 1, 4'h5, 101'h6, 1,   1, 1, 4'h5, 101'h6, 101'h6));
    tbl.push_back(mk(0, 0, 0, Z, 101'h0, 1,   0, 1, Z, 101'h6, 101'h0));
    tbl.push_back(mk(0, 0, 1, 4'hF, {1'b1, 100'h0}, 1,   1, 1, 4'hF, {1'b1, 100'h0}, {1'b1, 100'h0}));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ictrl, tbl[i].idata, tbl[i].ordy);
      step();
      chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
      chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(tbl[i].e_ir));
      chk($sformatf("v%0d out_ctrl", i), 128'(out_ctrl), 128'(tbl[i].e_ctrl));
      chk($sformatf("v%0d out_data", i), 128'(out_data), 128'(tbl[i].e_data));
      chk($sformatf("v%0d out_ctrl_z", i), 128'(out_ctrl_z), 128'(tbl[i].e_ctrl));
      chk($sformatf("v%0d out_data_z", i), 128'(out_data_z), 128'(tbl[i].e_data_z));
    end

`ifdef PIPE_STAGE_PERF_EN
    drive(1, 0, 0, Z, 101'h0, 0); step();
    drive(0, 0, 1, B, 101'hA, 0); step();   // bubble 1
    drive(0, 0, 1, B, 101'hB, 0); step();   // stall 1
    drive(0, 0, 0, Z, 101'h0, 0); step();   // stall 2
    drive(0, 0, 0, Z, 101'h0, 0); step();   // stall 3
    drive(0, 1, 0, Z, 101'h0, 1); step();   // flush of non-empty stage
    drive(0, 1, 0, Z, 101'h0, 0); step();   // bubble 2, flush while empty
    chk("stall_cnt", 128'(stall_cnt), 128'd3);
    chk("bubble_cnt", 128'(bubble_cnt), 128'd2);
    chk("flush_cnt", 128'(flush_cnt), 128'd1);
`endif

    // Random backpressure against a FIFO model of depth two.
    drive(1, 0, 0, Z, 101'h0, 0);
    step();
    q.delete();
    seq = 1;
    for (int c = 0; c < 300; c++) begin
      drive(0, 0, 1'($urandom_range(0, 1)), 4'($urandom), 101'(seq), ($urandom_range(0, 3) != 0));
      in_x  = in_valid && (q.size() < 2);
      out_x = (q.size() > 0) && out_ready;
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        q.push_back('{ctrl: in_ctrl, data: in_data});
        seq++;
      end
      step();
      chk("rnd out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("rnd in_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd out_ctrl", 128'(out_ctrl), 128'(q[0].ctrl));
        chk("rnd out_data", 128'(out_data), 128'(q[0].data));
        chk("rnd out_data_z", 128'(out_data_z), 128'(q[0].data));
      end else begin
        chk("rnd bubble ctrl", 128'(out_ctrl), 128'd0);
        chk("rnd bubble data_z", 128'(out_data_z), 128'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic pipeline stage register that replaces the fixed stage registers between the pipeline stages (for example execute to memory).
- Carries a control bundle and a data bundle with a valid/ready handshake.
- Holds a 2-entry skid buffer, so backpressure never drops an instruction and in_ready stays fully registered.
- Supports flush (bubble insertion) and forces control fields to zero on any bubble, so downstream stages never act on stale control.

Parameters:
CTRL_W, 4, width of control bundle (e.g. reg_write, result_src[1:0], mem_write); zeroed on bubble/flush.
DATA_W, 101, width of data bundle (e.g. alu_result, write_data, rd, pc_plus4); retains last value on bubble unless ZERO_DATA=1.
ZERO_DATA, 0, 1 = data bundle also driven to zero whenever out_valid=0.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all held entries and the current input this cycle
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept; registered, depends only on internal state
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  out_ctrl/out_data hold a valid instruction
out_ready  input  1  downstream accepts (0 = stall)
out_ctrl  output  CTRL_W  control bundle; all-zero whenever out_valid=0
out_data  output  DATA_W  data bundle; zero when out_valid=0 and ZERO_DATA=1

Behaviour:
- Storage and states:
  - Two entries: main (drives outputs) and skid.
  - States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- Handshake:
  - Input transfer: in_valid & in_ready & !flush.
  - Output transfer: out_valid & out_ready.
- Registered outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- Transitions when flush=0:
  - EMPTY: on input transfer, load main, go to ONE.
  - ONE, input and output transfer together: main <= input, stay in ONE (full throughput, 1 instr/cycle).
  - ONE, input transfer only: skid <= input, go to TWO.
  - ONE, output transfer only: go to EMPTY.
  - ONE, neither: hold.
  - TWO: no input is accepted (in_ready=0). On output transfer, main <= skid and go to ONE. Otherwise hold.
- Latency and ordering:
  - Latency in_valid to out_valid is 1 cycle when EMPTY or ONE with no stall.
  - Strict FIFO order is preserved; no entry is lost or duplicated.
- Flush:
  - Next state is EMPTY regardless of state, in_valid or out_ready.
  - The input present in the flush cycle is dropped.
  - An output transfer in the flush cycle still counts as consumed.
- Reset:
  - rst has priority over flush.
  - state=EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, skid contents=0.
  - Reset mid-stall discards both entries.
- Bubble masking:
  - out_ctrl is gated combinationally by out_valid, so it reads 0 when EMPTY.
  - Same for out_data when ZERO_DATA=1.
- Stable holding: while out_valid=1 and out_ready=0, out_ctrl and out_data must not change.
- Widths: CTRL_W >= 1 and DATA_W >= 1. No arithmetic on the payload; the payload is passed through bit-exact.

Optional Feature:
Macro PIPE_STAGE_PERF_EN adds three output counters, each 32 bits, wrapping at 2^32, and cleared by rst:
- stall_cnt: cycles with out_valid & !out_ready.
- bubble_cnt: cycles with !out_valid.
- flush_cnt: cycles with flush=1 while state != EMPTY.

Without the macro these ports and their logic do not exist, and the core behaviour is identical.

Test Plan:
1. Reset, then in_valid=1 each cycle with in_ctrl=4'b1011 and data=0x1..0x5, out_ready=1 → out_valid rises 1 cycle later; outputs 0x1..0x5 in order, one per cycle; in_ready stays 1.
2. Load 0xA, then hold out_ready=0 and offer 0xB, 0xC:
   - 0xB is accepted into skid and in_ready falls to 0.
   - 0xC is held upstream; outputs stay at 0xA.
   - Release out_ready → 0xA, 0xB, 0xC delivered in order with no loss.
3. State TWO (0xA, 0xB) with flush=1 and in_valid=1 carrying 0xC → next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xC never appears.
4. ZERO_DATA=0 with state going ONE→EMPTY → out_ctrl=0 while out_data retains the last value. Same sequence with ZERO_DATA=1 → out_data=0.
5. rst asserted in state TWO together with flush=1 and in_valid=1 → next cycle out_valid=0, in_ready=1, all outputs 0; the first post-reset input appears after 1 cycle.
6. PIPE_STAGE_PERF_EN defined, with 3 stall cycles, 2 empty cycles and 1 flush of a non-empty stage → stall_cnt=3, bubble_cnt=2 (excluding reset cycles), flush_cnt=1.
